// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell per clock, LSB first, with the
// borrow carried between cycles in a flip-flop. Result and final borrow are held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] xy,
  output logic             borrowOut
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             nextState_s;
  logic [WIDTH-1:0]   xs_r;
  logic [WIDTH-1:0]   ys_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   resShift_s;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               diffBit_s;
  logic               borrowNext_s;
  logic               lastBit_s;

  function automatic logic fsDiff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fsBorrow(input logic a, input logic b, input logic bin);
    return (~a & (b ^ bin)) | (b & bin);
  endfunction

  // Full-subtractor cell, result shift-in and next-state decode
  always_comb begin
    diffBit_s    = fsDiff(xs_r[0], ys_r[0], borrow_r);
    borrowNext_s = fsBorrow(xs_r[0], ys_r[0], borrow_r);
    resShift_s   = res_r >> 1'b1;
    resShift_s[WIDTH-1] = diffBit_s;
    lastBit_s    = (cnt_r == LAST_BIT);
    nextState_s  = state_r;
    case (state_r)
      IDLE: begin
        if (start) nextState_s = SHIFT;
        else       nextState_s = IDLE;
      end
      SHIFT: begin
        if (lastBit_s) nextState_s = DONE;
        else           nextState_s = SHIFT;
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Datapath, state register and registered status/result outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      xy        <= {WIDTH{1'b0}};
      borrowOut <= 1'b0;
      xs_r      <= {WIDTH{1'b0}};
      ys_r      <= {WIDTH{1'b0}};
      res_r     <= {WIDTH{1'b0}};
      borrow_r  <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= nextState_s;
      busy    <= (nextState_s != IDLE);
      done    <= (nextState_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            xs_r     <= x;
            ys_r     <= y;
            borrow_r <= borrowIn;
            res_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          xs_r     <= xs_r >> 1'b1;
          ys_r     <= ys_r >> 1'b1;
          res_r    <= resShift_s;
          borrow_r <= borrowNext_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // Only the completing edge exposes the result
          if (lastBit_s) begin
            xy        <= resShift_s;
            borrowOut <= borrowNext_s;
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench: an 8-bit instance for latency, borrow, busy-ignore
// and reset-abort cases, plus a 2-bit instance swept over every operand combination.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       resetN;

  logic       start8, bin8, busy8, done8, bo8;
  logic [7:0] x8, y8, xy8;

  logic       start2, bin2, busy2, done2, bo2;
  logic [1:0] x2, y2, xy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .resetN(resetN), .start(start8), .x(x8), .y(y8), .borrowIn(bin8),
    .busy(busy8), .done(done8), .xy(xy8), .borrowOut(bo8)
  );

  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .resetN(resetN), .start(start2), .x(x2), .y(y2), .borrowIn(bin2),
    .busy(busy2), .done(done2), .xy(xy2), .borrowOut(bo2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation with exact latency checks around the completion edge
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] expXy, input logic expBo);
    x8 = a; y8 = b; bin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    x8 = ~a; y8 = ~b; bin8 = ~c;
    check({tag, "_busyE0"}, {31'd0, busy8}, 32'd1);
    repeat (7) tick();
    check({tag, "_doneE7"}, {31'd0, done8}, 32'd0);
    tick();
    check({tag, "_doneE8"}, {31'd0, done8}, 32'd1);
    check({tag, "_xy"}, {24'd0, xy8}, {24'd0, expXy});
    check({tag, "_bo"}, {31'd0, bo8}, {31'd0, expBo});
    tick();
    check({tag, "_doneE9"}, {31'd0, done8}, 32'd0);
    check({tag, "_busyE9"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    resetN = 1'b0;
    start8 = 1'b1; x8 = 8'h5A; y8 = 8'h23; bin8 = 1'b0;
    start2 = 1'b1; x2 = 2'd3;  y2 = 2'd1;  bin2 = 1'b0;
    #1;
    tick();
    tick();
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_xy",   {24'd0, xy8},   32'd0);
    check("rst_bo",   {31'd0, bo8},   32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    start8 = 1'b0; start2 = 1'b0;
    resetN = 1'b1;
    repeat (3) tick();
    check("rst_noStart", {31'd0, busy8}, 32'd0);

    op8("basic", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    op8("wrap0", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    op8("eqBin", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    op8("msb",   8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // start pulsed mid-operation must be ignored
    x8 = 8'h09; y8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (2) tick();
    x8 = 8'hFF; y8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    check("ign_doneE7", {31'd0, done8}, 32'd0);
    tick();
    check("ign_doneE8", {31'd0, done8}, 32'd1);
    check("ign_xy", {24'd0, xy8}, 32'h05);
    check("ign_bo", {31'd0, bo8}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ign_noDone", {31'd0, done8}, 32'd0);
      check("ign_hold", {24'd0, xy8}, 32'h05);
    end
    check("ign_idle", {31'd0, busy8}, 32'd0);

    // reset in the middle of an operation aborts it
    x8 = 8'h5A; y8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    resetN = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_xy", {24'd0, xy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_noDone", {31'd0, done8}, 32'd0);
    end
    op8("postRst", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

    // 2-bit sweep, back to back: accept, done two edges later, idle on the third
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          int expD;
          int expB;
          int waitCnt;
          expD = (a - b - c) & 3;
          expB = (a < (b + c)) ? 1 : 0;
          x2 = 2'(a); y2 = 2'(b); bin2 = 1'(c); start2 = 1'b1;
          tick();
          start2 = 1'b0;
          waitCnt = 0;
          while (done2 !== 1'b1 && waitCnt < 10) begin
            tick();
            waitCnt++;
          end
          check($sformatf("w2_lat_%0d_%0d_%0d", a, b, c), 32'(waitCnt), 32'd2);
          check($sformatf("w2_xy_%0d_%0d_%0d", a, b, c), {30'd0, xy2}, 32'(expD));
          check($sformatf("w2_bo_%0d_%0d_%0d", a, b, c), {31'd0, bo2}, 32'(expB));
          tick();
          check($sformatf("w2_idle_%0d_%0d_%0d", a, b, c), {31'd0, busy2}, 32'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial multi-bit subtractor built around a single full-subtractor cell and a registered borrow. It accepts two WIDTH-bit operands on a start pulse, processes one bit per clock LSB-first, and presents the registered difference and final borrow with a one-cycle done pulse. It is the sequential consumer of the full-subtractor cell: it feeds the cell's borrowOut back into its borrowIn through a flip-flop across cycles.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all state updates on rising edge
resetN  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only when busy=0
x  input  WIDTH  minuend; sampled on accepting edge only
y  input  WIDTH  subtrahend; sampled on accepting edge only
borrowIn  input  1  initial borrow into bit 0; sampled on accepting edge only
busy  output  1  high while an operation is in progress (SHIFT or DONE)
done  output  1  one-cycle pulse; result valid
xy  output  WIDTH  registered difference; holds until next completion
borrowOut  output  1  registered borrow out of MSB; holds with xy

Behaviour:
- Reset (resetN=0 at rising edge): state=IDLE, busy=0, done=0, xy=0, borrowOut=0, internal shift registers, borrow register and bit counter cleared. Overrides all other inputs, including start in the same cycle.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge → latch x, y into shift registers, borrow register := borrowIn, counter := 0, go to SHIFT. start=0 → stay.
- SHIFT: each edge processes bit 0 of the shift registers:
  - d = xs[0] ^ ys[0] ^ b; b_next = (~xs[0] & (ys[0] ^ b)) | (ys[0] & b).
  - Operand registers shift right by 1. d enters result shift register at MSB, shifting right. b := b_next. counter++.
  - On the edge processing bit WIDTH-1: xy := completed result, borrowOut := b_next, go to DONE.
- DONE: done=1 for exactly this cycle; next edge → IDLE.
- busy = (state != IDLE), a registered-state decode.
- Latency: start accepted at edge E0; xy/borrowOut update and done rises at edge E_WIDTH; done falls and busy falls at edge E_(WIDTH+1). Minimum start-to-start spacing WIDTH+2 cycles.
- start while busy=1 (SHIFT or DONE): ignored, no queuing; operands and borrowIn are not resampled.
- Input changes on x/y/borrowIn after the accepting edge do not affect the result.
- Arithmetic: xy = (x − y − borrowIn) mod 2^WIDTH, all unsigned. borrowOut = 1 iff x < y + borrowIn.
- WIDTH=1: SHIFT lasts one edge; done at E1.
- xy and borrowOut change only at completion edges or reset; they are never exposed as partial results.
- Reset mid-operation: aborts; no done pulse for the aborted op; outputs return to reset values; the next start behaves as from power-up.
- Counter width: enough to count 0..WIDTH−1.

Test Plan:
- Reset: hold resetN=0 two cycles with start=1 → busy=0, done=0, xy=0x00, borrowOut=0. No operation starts after release until start is reasserted.
- WIDTH=8; x=0x5A, y=0x23, borrowIn=0, start one cycle → busy high from E0, done high exactly between E8 and E9, xy=0x37, borrowOut=0. busy low after E9.
- WIDTH=8 wrap/borrow: x=0x00, y=0x01, bin=0 → xy=0xFF, borrowOut=1. x=0x10, y=0x10, bin=1 → xy=0xFF, borrowOut=1. x=0x80, y=0x7F, bin=1 → xy=0x00, borrowOut=0.
- Busy-ignore: start with x=0x09, y=0x04, bin=0; at E3 pulse start with x=0xFF, y=0x00 → single done, xy=0x05, borrowOut=0. Result held unchanged for 5 idle cycles after done.
- Reset mid-op: start x=0x5A, y=0x23, then resetN=0 at E4 → busy=0, xy=0, no done pulse. Release, start x=0x03, y=0x05, bin=0 → xy=0xFE, borrowOut=1 at E8.
- Exhaustive: WIDTH=2 instance, all 32 {x,y,borrowIn} combinations back-to-back, start asserted as soon as busy=0 → every result matches the mod-4 formula. Spacing between starts is exactly 4 cycles.
